seq_enable_accum_reg: RTL and testbench
=======================================

Name: seq_enable_accum_reg

Overview:
- Parametrised successor to the single-width enable register: a WIDTH-bit register with an opcode-selected next-state action.
- Actions: hold, load, increment, decrement, add, accumulate.
- Optional saturation, sticky overflow, and a terminal-count event with optional auto-reload.
- Serves as the sequential-inference benchmark and reusable counter/accumulator primitive for frontend regression designs.

Parameters:
- WIDTH, 8, datapath width of a, b, d, q (≥2).
- RST_VAL, '0, value of q on asynchronous reset and on clr.
- STEP, 1, increment/decrement amount; truncated to WIDTH bits.
- SATURATE, 0, 1 clamps results to all-ones or zero; 0 wraps modulo 2^WIDTH.
- TC_VAL, '1, terminal-count compare value for INC.
- AUTO_RELOAD, 0, 1 loads d instead of incrementing when INC executes at q==TC_VAL.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- clr  input  1  synchronous clear; overrides en.
- en  input  1  action enable; when low, all state holds.
- op  input  3  action select (op_e).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- d  input  WIDTH  load / reload value.
- q  output  WIDTH  register value.
- ovf  output  1  sticky overflow/underflow flag.
- tc  output  1  one-cycle terminal-count pulse.

Behaviour:
- Reset and clock: one clock domain, clk. rst is asynchronous, active-high. On rst: q=RST_VAL, ovf=0, tc=0 immediately, independent of clk.
- Priority per rising edge: rst > clr > en > hold.
- clr=1: q<=RST_VAL, ovf<=0, tc<=0, regardless of en/op.
- en=0 and clr=0: q and ovf hold; tc<=0.
- en=1 actions by op; all arithmetic is computed at WIDTH+1 bits and the carry/borrow bit is the overflow event:
  - OP_HOLD (0): q unchanged, no event.
  - OP_LOAD (1): q<=d, no event.
  - OP_INC (2): q<=q+STEP; carry out = event.
  - OP_DEC (3): q<=q-STEP; borrow = event.
  - OP_ADD (4): q<=a+b; carry = event. Result is independent of q.
  - OP_ACC (5): q<=q+a; carry = event.
  - Codes 6 and 7: treated as HOLD, no event.
- Overflow event:
  - ovf<=1, sticky until clr or rst.
  - SATURATE=1: q<=all-ones on carry, q<=0 on borrow.
  - SATURATE=0: q takes the low WIDTH bits.
- Terminal count (OP_INC with en=1, clr=0, q==TC_VAL):
  - tc<=1 for exactly the following cycle.
  - AUTO_RELOAD=1: q<=d, and no overflow event is raised for that cycle.
  - AUTO_RELOAD=0: normal INC result, including wrap/saturate and the ovf rule.
- tc is 0 in every other cycle. Back-to-back terminal events produce consecutive tc pulses.
- Latency: all outputs are registered. Results are visible one cycle after the sampling edge. No combinational input-to-output paths.
- Reset mid-operation: rst asserted between edges clears q, ovf and tc immediately. The first edge after deassertion evaluates normally.

Decomposition:
- Package seq_accum_pkg:
  - op_e enum (OP_HOLD..OP_ACC, 3-bit), with reserved codes documented.
  - localparam OP_W=3.
- Sub-module seq_accum_addsub (combinational):
  - Inputs: x, y, sub.
  - Outputs: WIDTH-bit result and carry/borrow.
  - Shared by INC, DEC, ADD and ACC through operand muxing.
- Top module holds the q/ovf/tc registers, the opcode mux, saturation, and the TC/reload logic.

Test Plan (WIDTH=8, RST_VAL=0, STEP=1 unless stated):
- Async reset: q=8'h5A via LOAD; assert rst mid-cycle → q=0, ovf=0, tc=0 before the next edge. Release; LOAD d=8'h11 → q=8'h11.
- Priority and hold:
  - clr=1, en=1, op=LOAD, d=8'hFF → q=0.
  - en=0, op=INC for 3 cycles → q unchanged, tc=0.
  - op=6 with en=1 → q unchanged.
- Wrap vs saturate:
  - q=8'hFE, INC×2, SATURATE=0 → q=FF then 00, ovf=1 after the second edge, and stays 1.
  - Same stimulus with SATURATE=1 → q=FF, FF, ovf=1.
  - DEC from 0 → q=FF (wrap) or 0 (saturate), ovf=1.
- ADD/ACC:
  - a=8'h80, b=8'h7F → q=8'hFF, ovf=0.
  - Then ACC with a=8'h02 → q=8'h01 (wrap), ovf=1.
  - clr → ovf=0.
- Terminal count with AUTO_RELOAD=1, TC_VAL=8'h05, d=8'h02:
  - Continuous INC from 3 → q=4, 5, 2, 3, 4, 5, 2.
  - tc high for exactly one cycle coincident with each q=2 after reload.
  - ovf stays 0.

Source files
------------

// File: rtl/seq_accum_pkg.sv
// Shared opcode definitions for the enable/accumulate register.
package seq_accum_pkg;

  localparam int unsigned OP_W = 3;

  // Codes 3'd6 and 3'd7 are reserved and execute as OP_HOLD with no event.
  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_ADD  = 3'd4,
    OP_ACC  = 3'd5
  } op_e;

endpackage

// File: rtl/seq_accum_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-out (add) or borrow (sub).
module seq_accum_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  logic [WIDTH:0] full;

  // Bit WIDTH is the carry on add and the borrow on subtract.
  assign full = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  assign res  = full[WIDTH-1:0];
  assign cout = full[WIDTH];

endmodule

// File: rtl/seq_enable_accum_reg.sv
// Opcode-driven register: hold/load/inc/dec/add/acc with optional saturation,
// sticky overflow and a terminal-count pulse with optional auto-reload.
module seq_enable_accum_reg
  import seq_accum_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RST_VAL     = '0,
  parameter int unsigned      STEP        = 1,
  parameter bit               SATURATE    = 1'b0,
  parameter logic [WIDTH-1:0] TC_VAL      = '1,
  parameter bit               AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             ovf,
  output logic             tc
);

  localparam logic [WIDTH-1:0] StepVal = WIDTH'(STEP);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q;
  logic             tc_q;

  op_e              op_sel;
  logic [WIDTH-1:0] x, y, sum;
  logic             sub, arith, cout, evt, tc_hit;

  assign op_sel = op_e'(op);

  seq_accum_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .x    (x),
    .y    (y),
    .sub  (sub),
    .res  (sum),
    .cout (cout)
  );

  always_comb begin
    x      = q_q;
    y      = StepVal;
    sub    = 1'b0;
    arith  = 1'b0;
    q_d    = q_q;
    evt    = 1'b0;
    tc_hit = 1'b0;

    case (op_sel)
      OP_LOAD: q_d = d;
      OP_INC:  arith = 1'b1;
      OP_DEC: begin
        arith = 1'b1;
        sub   = 1'b1;
      end
      OP_ADD: begin
        x     = a;
        y     = b;
        arith = 1'b1;
      end
      OP_ACC: begin
        y     = a;
        arith = 1'b1;
      end
      default: ;
    endcase

    evt = arith & cout;
    if (arith) begin
      q_d = (evt && SATURATE) ? (sub ? '0 : '1) : sum;
    end

    tc_hit = (op_sel == OP_INC) && (q_q == TC_VAL);
    // Reload replaces the increment outright, so no overflow can be raised.
    if (tc_hit && AUTO_RELOAD) begin
      q_d = d;
      evt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RST_VAL;
      ovf_q <= 1'b0;
      tc_q  <= 1'b0;
    end else if (clr) begin
      q_q   <= RST_VAL;
      ovf_q <= 1'b0;
      tc_q  <= 1'b0;
    end else if (en) begin
      q_q   <= q_d;
      ovf_q <= ovf_q | evt;
      tc_q  <= tc_hit;
    end else begin
      tc_q  <= 1'b0;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  assign tc  = tc_q;

endmodule

// File: tb/tb_seq_enable_accum_reg.sv
// Bench for seq_enable_accum_reg: three configurations (wrap, saturate,
// auto-reload at 5) share stimulus and are compared against a behavioural model.
module tb_seq_enable_accum_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       en  = 1'b0;
  logic [2:0] op  = 3'd0;
  logic [7:0] a   = 8'h00;
  logic [7:0] b   = 8'h00;
  logic [7:0] d   = 8'h00;

  logic [7:0] qw   [3];
  logic       ovfw [3];
  logic       tcw  [3];

  // Per-instance configuration mirrored by the model.
  int sat_cfg [3] = '{0, 1, 0};
  int tcv_cfg [3] = '{255, 255, 5};
  int ar_cfg  [3] = '{0, 0, 1};

  int mq [3];
  int movf [3];
  int mtc [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_enable_accum_reg #(
    .WIDTH (8), .RST_VAL (8'h00), .STEP (1), .SATURATE (1'b0),
    .TC_VAL (8'hFF), .AUTO_RELOAD (1'b0)
  ) u_wrap (
    .clk (clk), .rst (rst), .clr (clr), .en (en), .op (op),
    .a (a), .b (b), .d (d), .q (qw[0]), .ovf (ovfw[0]), .tc (tcw[0])
  );

  seq_enable_accum_reg #(
    .WIDTH (8), .RST_VAL (8'h00), .STEP (1), .SATURATE (1'b1),
    .TC_VAL (8'hFF), .AUTO_RELOAD (1'b0)
  ) u_sat (
    .clk (clk), .rst (rst), .clr (clr), .en (en), .op (op),
    .a (a), .b (b), .d (d), .q (qw[1]), .ovf (ovfw[1]), .tc (tcw[1])
  );

  seq_enable_accum_reg #(
    .WIDTH (8), .RST_VAL (8'h00), .STEP (1), .SATURATE (1'b0),
    .TC_VAL (8'h05), .AUTO_RELOAD (1'b1)
  ) u_rld (
    .clk (clk), .rst (rst), .clr (clr), .en (en), .op (op),
    .a (a), .b (b), .d (d), .q (qw[2]), .ovf (ovfw[2]), .tc (tcw[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s q[%0d]", tag, k), 32'(qw[k]), 32'(mq[k]));
      check($sformatf("%s ovf[%0d]", tag, k), 32'(ovfw[k]), 32'(movf[k]));
      check($sformatf("%s tc[%0d]", tag, k), 32'(tcw[k]), 32'(mtc[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0; movf[k] = 0; mtc[k] = 0;
    end
  endtask

  // Next state from the rules: rst > clr > en > hold, 8-bit unsigned arithmetic.
  task automatic model_step();
    int r;
    int ov;
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        mq[k] = 0; movf[k] = 0; mtc[k] = 0;
      end else if (!en) begin
        mtc[k] = 0;
      end else begin
        mtc[k] = (op == 3'd2 && mq[k] == tcv_cfg[k]) ? 1 : 0;
        ov = 0;
        r  = mq[k];
        if (mtc[k] == 1 && ar_cfg[k] == 1) r = int'(d);
        else begin
          case (op)
            3'd1: r = int'(d);
            3'd2: r = mq[k] + 1;
            3'd3: r = mq[k] - 1;
            3'd4: r = int'(a) + int'(b);
            3'd5: r = mq[k] + int'(a);
            default: r = mq[k];
          endcase
          if (r > 255) begin
            ov = 1;
            r  = (sat_cfg[k] == 1) ? 255 : r - 256;
          end else if (r < 0) begin
            ov = 1;
            r  = (sat_cfg[k] == 1) ? 0 : r + 256;
          end
        end
        mq[k] = r;
        if (ov == 1) movf[k] = 1;
      end
    end
  endtask

  task automatic drive(input logic c, input logic e, input logic [2:0] o,
                       input logic [7:0] av, input logic [7:0] bv, input logic [7:0] dv);
    clr = c; en = e; op = o; a = av; b = bv; d = dv;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  int exp_rld [7] = '{4, 5, 2, 3, 4, 5, 2};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Async reset between edges
    drive(0, 1, 3'd1, 8'h00, 8'h00, 8'h5A); step("load_5a");
    check("load_5a_const", 32'(qw[0]), 32'h5A);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    drive(0, 1, 3'd1, 8'h00, 8'h00, 8'h11); step("load_11");
    check("load_11_const", 32'(qw[0]), 32'h11);

    // Priority and hold
    drive(1, 1, 3'd1, 8'h00, 8'h00, 8'hFF); step("clr_over_load");
    check("clr_const", 32'(qw[0]), 32'h00);
    drive(0, 1, 3'd1, 8'h00, 8'h00, 8'h42); step("load_42");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 3'd2, 8'h00, 8'h00, 8'h00); step("en_low_hold");
    end
    check("en_low_const", 32'(qw[0]), 32'h42);
    drive(0, 1, 3'd6, 8'h33, 8'h44, 8'h55); step("op6_hold");
    drive(0, 1, 3'd7, 8'h33, 8'h44, 8'h55); step("op7_hold");

    // Wrap vs saturate
    drive(0, 1, 3'd1, 8'h00, 8'h00, 8'hFE); step("load_fe");
    drive(0, 1, 3'd2, 8'h00, 8'h00, 8'h00); step("inc_ff");
    step("inc_wrap");
    check("wrap_q_const", 32'(qw[0]), 32'h00);
    check("sat_q_const", 32'(qw[1]), 32'hFF);
    check("wrap_ovf_const", 32'(ovfw[0]), 32'h1);
    drive(0, 1, 3'd0, 8'h00, 8'h00, 8'h00); step("ovf_sticky");
    drive(1, 0, 3'd0, 8'h00, 8'h00, 8'h00); step("clr1");
    drive(0, 1, 3'd3, 8'h00, 8'h00, 8'h00); step("dec_from_0");
    check("dec_wrap_const", 32'(qw[0]), 32'hFF);
    check("dec_sat_const", 32'(qw[1]), 32'h00);

    // ADD / ACC
    drive(1, 0, 3'd0, 8'h00, 8'h00, 8'h00); step("clr2");
    drive(0, 1, 3'd4, 8'h80, 8'h7F, 8'h00); step("add_80_7f");
    check("add_const", 32'(qw[0]), 32'hFF);
    drive(0, 1, 3'd5, 8'h02, 8'h00, 8'h00); step("acc_wrap");
    check("acc_const", 32'(qw[0]), 32'h01);
    check("acc_ovf_const", 32'(ovfw[0]), 32'h1);
    drive(1, 1, 3'd5, 8'h02, 8'h00, 8'h00); step("clr_ovf");

    // Terminal count with reload on u_rld
    drive(0, 1, 3'd1, 8'h00, 8'h00, 8'h03); step("load_3");
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 3'd2, 8'h00, 8'h00, 8'h02); step("tc_inc");
      check($sformatf("rld_seq%0d", i), 32'(qw[2]), 32'(exp_rld[i]));
      check($sformatf("rld_tc%0d", i), 32'(tcw[2]), (exp_rld[i] == 2) ? 32'h1 : 32'h0);
    end
    check("rld_ovf_const", 32'(ovfw[2]), 32'h0);

    // Randomised traffic; loads near the compare values keep tc reachable.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] dv;
      dv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) :
           ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            3'($urandom), 8'($urandom), 8'($urandom), dv);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
